// File: rtl/mips_dbg_pkg.sv
// Shared types for the mini-MIPS retire-trace buffer.
// Each record is packed as {pc, instr, wdata}, with pc in the most significant bits.
package mips_dbg_pkg;

    localparam int unsigned DFLT_PC_W    = 5;
    localparam int unsigned DFLT_INSTR_W = 16;
    localparam int unsigned DFLT_DATA_W  = 32;
    localparam int unsigned ENTRY_W      = DFLT_PC_W + DFLT_INSTR_W + DFLT_DATA_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        POST  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    // One record at the default widths; the field order is the packing order.
    typedef struct packed {
        logic [DFLT_PC_W-1:0]    pc;
        logic [DFLT_INSTR_W-1:0] instr;
        logic [DFLT_DATA_W-1:0]  wdata;
    } trace_entry_t;

endpackage

// File: rtl/mips_trace_buffer_if.sv
// Capture tap and drain stream of the trace buffer.
// The slave modport is the buffer side; master is the core tap plus the drain consumer.
interface mips_trace_buffer_if
    import mips_dbg_pkg::*;
#(
    parameter int unsigned PC_W    = DFLT_PC_W,
    parameter int unsigned INSTR_W = DFLT_INSTR_W,
    parameter int unsigned DATA_W  = DFLT_DATA_W
);
    logic               cap_valid;
    logic [PC_W-1:0]    cap_pc;
    logic [INSTR_W-1:0] cap_instr;
    logic [DATA_W-1:0]  cap_wdata;

    logic               rd_ready;
    logic               rd_valid;
    logic [PC_W-1:0]    rd_pc;
    logic [INSTR_W-1:0] rd_instr;
    logic [DATA_W-1:0]  rd_wdata;
    logic               rd_last;

    modport master (
        output cap_valid, cap_pc, cap_instr, cap_wdata, rd_ready,
        input  rd_valid, rd_pc, rd_instr, rd_wdata, rd_last
    );

    modport slave (
        input  cap_valid, cap_pc, cap_instr, cap_wdata, rd_ready,
        output rd_valid, rd_pc, rd_instr, rd_wdata, rd_last
    );
endinterface

// File: rtl/trace_ram.sv
// Record storage: one synchronous write port and one asynchronous read port.
// The storage array has no reset.
module trace_ram #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 53,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/mips_trace_buffer.sv
// Retire-trace capture buffer for the mini-MIPS core.
// Records into a ring, freezes on a pc trigger or on stop, then drains oldest-first.
module mips_trace_buffer
    import mips_dbg_pkg::*;
#(
    parameter int unsigned PC_W      = DFLT_PC_W,
    parameter int unsigned INSTR_W   = DFLT_INSTR_W,
    parameter int unsigned DATA_W    = DFLT_DATA_W,
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned POST_TRIG = 8,
    localparam int unsigned AW       = $clog2(DEPTH),
    localparam int unsigned CW       = AW + 1
) (
    input  logic            clk,
    input  logic            rst_n,
    mips_trace_buffer_if.slave bus,
    input  logic            arm,
    input  logic            trig_en,
    input  logic [PC_W-1:0] trig_pc,
    input  logic            stop,
    output logic [1:0]      state,
    output logic [CW-1:0]   count,
    output logic            overflow
);
    localparam int unsigned ENT_W = PC_W + INSTR_W + DATA_W;

    state_t             state_q, state_d;
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]      post_q, post_d;
    logic [CW-1:0]      count_q, count_d;
    logic [CW-1:0]      rem_q, rem_d;
    logic               ovf_q, ovf_d;
    logic               rd_valid_q, rd_valid_d;
    logic               rd_last_q, rd_last_d;
    logic [ENT_W-1:0]   rd_ent_q, rd_ent_d;

    logic               we_c;
    logic               drain_go_c;
    logic [ENT_W-1:0]   ram_rdata_c;

    trace_ram #(
        .DEPTH (DEPTH),
        .WIDTH (ENT_W)
    ) u_ram (
        .clk   (clk),
        .we    (we_c),
        .waddr (wr_ptr_q),
        .wdata ({bus.cap_pc, bus.cap_instr, bus.cap_wdata}),
        .raddr (rd_ptr_q),
        .rdata (ram_rdata_c)
    );

    // Next-state and datapath; stop outranks a same-cycle record.
    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        post_d     = post_q;
        count_d    = count_q;
        rem_d      = rem_q;
        ovf_d      = ovf_q;
        rd_valid_d = rd_valid_q;
        rd_last_d  = rd_last_q;
        rd_ent_d   = rd_ent_q;
        we_c       = 1'b0;
        drain_go_c = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (arm) begin
                    wr_ptr_d = '0;
                    count_d  = '0;
                    ovf_d    = 1'b0;
                    state_d  = ARMED;
                end
            end
            ARMED, POST: begin
                if (stop) begin
                    if (count_q != '0) begin
                        state_d    = DRAIN;
                        drain_go_c = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (bus.cap_valid) begin
                    we_c     = 1'b1;
                    wr_ptr_d = wr_ptr_q + AW'(1);
                    if (count_q == CW'(DEPTH)) begin
                        ovf_d = 1'b1;
                    end else begin
                        count_d = count_q + CW'(1);
                    end
                    if (state_q == ARMED) begin
                        if (trig_en && (bus.cap_pc == trig_pc)) begin
                            if (POST_TRIG == 0) begin
                                state_d    = DRAIN;
                                drain_go_c = 1'b1;
                            end else begin
                                state_d = POST;
                                post_d  = AW'(POST_TRIG);
                            end
                        end
                    end else begin
                        post_d = post_q - AW'(1);
                        if (post_q == AW'(1)) begin
                            state_d    = DRAIN;
                            drain_go_c = 1'b1;
                        end
                    end
                end
            end
            DRAIN: begin
                // rem_q counts records not yet accepted, including the one on display.
                if (!rd_valid_q) begin
                    rd_ent_d   = ram_rdata_c;
                    rd_valid_d = 1'b1;
                    rd_last_d  = (rem_q == CW'(1));
                    rd_ptr_d   = rd_ptr_q + AW'(1);
                end else if (bus.rd_ready) begin
                    if (rd_last_q) begin
                        rd_valid_d = 1'b0;
                        rd_last_d  = 1'b0;
                        count_d    = '0;
                        state_d    = IDLE;
                    end else begin
                        rd_ent_d  = ram_rdata_c;
                        rd_ptr_d  = rd_ptr_q + AW'(1);
                        rem_d     = rem_q - CW'(1);
                        rd_last_d = (rem_q == CW'(2));
                    end
                end
            end
        endcase

        // Oldest record sits count slots behind the write pointer.
        if (drain_go_c) begin
            rd_ptr_d = wr_ptr_d - AW'(count_d);
            rem_d    = count_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            post_q     <= '0;
            count_q    <= '0;
            rem_q      <= '0;
            ovf_q      <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_last_q  <= 1'b0;
            rd_ent_q   <= '0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            post_q     <= post_d;
            count_q    <= count_d;
            rem_q      <= rem_d;
            ovf_q      <= ovf_d;
            rd_valid_q <= rd_valid_d;
            rd_last_q  <= rd_last_d;
            rd_ent_q   <= rd_ent_d;
        end
    end

    assign state        = state_q;
    assign count        = count_q;
    assign overflow     = ovf_q;
    assign bus.rd_valid = rd_valid_q;
    assign bus.rd_last  = rd_last_q;
    assign bus.rd_pc    = rd_ent_q[ENT_W-1 -: PC_W];
    assign bus.rd_instr = rd_ent_q[DATA_W +: INSTR_W];
    assign bus.rd_wdata = rd_ent_q[DATA_W-1:0];

endmodule

// File: tb/tb_mips_trace_buffer.sv
// Self-checking bench for mips_trace_buffer (DEPTH=8, POST_TRIG=3).
// Expected records are queued as they are fed and popped as the buffer drains them.
module tb_mips_trace_buffer;
    localparam int unsigned PC_W      = 5;
    localparam int unsigned INSTR_W   = 16;
    localparam int unsigned DATA_W    = 32;
    localparam int unsigned DEPTH     = 8;
    localparam int unsigned POST_TRIG = 3;
    localparam int unsigned CW        = 4;

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
        logic [DATA_W-1:0]  wdata;
    } rec_t;

    typedef struct {
        bit ten;
        int trig;
        int start;
        int n;
        int stop_at;
        int rdy;
        int gap;
        int exp_count;
        bit exp_ovf;
        int exp_first;
    } vec_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              arm, trig_en, stop;
    logic [PC_W-1:0]   trig_pc;
    logic [1:0]        state;
    logic [CW-1:0]     count;
    logic              overflow;

    int n_checks = 0;
    int n_fail   = 0;

    rec_t q[$];
    bit   m_frozen, m_in_post, m_ovf;
    int   m_post;
    vec_t vecs[6];

    always #5 clk = ~clk;

    mips_trace_buffer_if #(.PC_W(PC_W), .INSTR_W(INSTR_W), .DATA_W(DATA_W)) bus ();

    mips_trace_buffer #(
        .PC_W(PC_W), .INSTR_W(INSTR_W), .DATA_W(DATA_W),
        .DEPTH(DEPTH), .POST_TRIG(POST_TRIG)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .arm(arm), .trig_en(trig_en),
        .trig_pc(trig_pc), .stop(stop), .state(state), .count(count), .overflow(overflow)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference capture model: bounded queue, trigger and post-trigger countdown.
    task automatic model_cap(input rec_t r);
        if (m_frozen) return;
        if (q.size() == DEPTH) begin
            void'(q.pop_front());
            m_ovf = 1'b1;
        end
        q.push_back(r);
        if (!m_in_post) begin
            if (trig_en && r.pc == trig_pc) begin
                if (POST_TRIG == 0) m_frozen = 1'b1;
                else begin
                    m_in_post = 1'b1;
                    m_post    = POST_TRIG;
                end
            end
        end else begin
            m_post--;
            if (m_post == 0) m_frozen = 1'b1;
        end
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        rec_t r;
        rec_t e;
        bit   rdy;
        q.delete();
        m_frozen = 0; m_in_post = 0; m_ovf = 0; m_post = 0;
        // The arm cycle carries a record that must not be captured.
        trig_en = v.ten; trig_pc = PC_W'(v.trig);
        arm = 1'b1; bus.cap_valid = 1'b1; bus.cap_pc = 5'd30;
        bus.cap_instr = 16'hDEAD; bus.cap_wdata = 32'hDEADBEEF;
        @(negedge clk);
        arm = 1'b0; bus.cap_valid = 1'b0;
        chk($sformatf("v%0d armed", idx), 64'(state), 64'd1);

        for (int i = 0; i < v.n; i++) begin
            r.pc = PC_W'(v.start + i);
            r.instr = 16'($urandom);
            r.wdata = $urandom;
            bus.cap_valid = 1'b1; bus.cap_pc = r.pc;
            bus.cap_instr = r.instr; bus.cap_wdata = r.wdata;
            stop = (i == v.stop_at);
            if (stop) m_frozen = 1'b1;
            else model_cap(r);
            @(negedge clk);
            bus.cap_valid = 1'b0; stop = 1'b0;
            if (i == v.stop_at) break;
            if (i == 0) begin
                for (int g = 0; g < v.gap; g++) begin
                    arm = 1'b1;
                    @(negedge clk);
                    arm = 1'b0;
                    chk($sformatf("v%0d post_gap%0d", idx, g), 64'(state), 64'd2);
                end
            end
        end
        if (v.stop_at == v.n) begin
            stop = 1'b1; m_frozen = 1'b1;
            @(negedge clk);
            stop = 1'b0;
        end

        for (int k = 0; k < 8 && !bus.rd_valid; k++) @(negedge clk);
        chk($sformatf("v%0d drain_valid", idx), 64'(bus.rd_valid), 64'd1);
        chk($sformatf("v%0d drain_state", idx), 64'(state), 64'd3);
        chk($sformatf("v%0d count", idx), 64'(count), 64'(v.exp_count));
        chk($sformatf("v%0d overflow", idx), 64'(overflow), 64'(v.exp_ovf));
        chk($sformatf("v%0d first_pc", idx), 64'(bus.rd_pc), 64'(v.exp_first));
        arm = 1'b1;
        @(negedge clk);
        arm = 1'b0;
        chk($sformatf("v%0d arm_in_drain", idx), 64'(state), 64'd3);

        for (int k = 0; k < 200 && q.size() > 0; k++) begin
            rdy = (v.rdy == 0) ? 1'b1 : (k % 3 == 0);
            bus.rd_ready = rdy;
            e = q[0];
            chk($sformatf("v%0d rd_valid k%0d", idx, k), 64'(bus.rd_valid), 64'd1);
            chk($sformatf("v%0d rd_pc k%0d", idx, k), 64'(bus.rd_pc), 64'(e.pc));
            chk($sformatf("v%0d rd_last k%0d", idx, k), 64'(bus.rd_last), 64'(q.size() == 1));
            if (rdy && bus.rd_valid) begin
                chk($sformatf("v%0d rd_instr k%0d", idx, k), 64'(bus.rd_instr), 64'(e.instr));
                chk($sformatf("v%0d rd_wdata k%0d", idx, k), 64'(bus.rd_wdata), 64'(e.wdata));
                void'(q.pop_front());
            end
            @(negedge clk);
        end
        bus.rd_ready = 1'b0;
        if (q.size() != 0) chk($sformatf("v%0d drain_timeout", idx), 64'(q.size()), 64'd0);
        chk($sformatf("v%0d end_state", idx), 64'(state), 64'd0);
        chk($sformatf("v%0d end_valid", idx), 64'(bus.rd_valid), 64'd0);
        chk($sformatf("v%0d end_last", idx), 64'(bus.rd_last), 64'd0);
        chk($sformatf("v%0d end_count", idx), 64'(count), 64'd0);
        chk($sformatf("v%0d end_ovf", idx), 64'(overflow), 64'(v.exp_ovf));
    endtask

    initial begin
        //          ten trig start  n  stop rdy gap cnt ovf first
        vecs[0] = '{1,  2,   0,   10, -1,  0,  0,  6,  0,  0};
        vecs[1] = '{1,  12,  0,   21, -1,  0,  0,  8,  1,  8};
        vecs[2] = '{1,  2,   0,   10, -1,  1,  0,  6,  0,  0};
        vecs[3] = '{1,  31,  0,   4,   3,  0,  0,  3,  0,  0};
        vecs[4] = '{1,  4,   4,   4,  -1,  1,  3,  4,  0,  4};
        vecs[5] = '{0,  0,   0,   5,   5,  0,  0,  5,  0,  0};

        rst_n = 1'b0; arm = 0; trig_en = 0; stop = 0; trig_pc = '0;
        bus.cap_valid = 0; bus.cap_pc = '0; bus.cap_instr = '0; bus.cap_wdata = '0;
        bus.rd_ready = 0;
        repeat (2) @(negedge clk);
        chk("rst state", 64'(state), 64'd0);
        chk("rst count", 64'(count), 64'd0);
        chk("rst overflow", 64'(overflow), 64'd0);
        chk("rst rd_valid", 64'(bus.rd_valid), 64'd0);
        chk("rst rd_last", 64'(bus.rd_last), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);

        // Stop with nothing captured returns to IDLE without draining.
        arm = 1'b1; @(negedge clk); arm = 1'b0;
        stop = 1'b1; @(negedge clk); stop = 1'b0;
        chk("empty_stop state", 64'(state), 64'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("empty_stop rd_valid%0d", k), 64'(bus.rd_valid), 64'd0);
        end

        // Asynchronous reset while a record sits on the drain port.
        trig_en = 1'b1; trig_pc = 5'd11;
        arm = 1'b1; @(negedge clk); arm = 1'b0;
        for (int p = 10; p < 15; p++) begin
            bus.cap_valid = 1'b1; bus.cap_pc = PC_W'(p);
            bus.cap_instr = 16'h1000 + 16'(p); bus.cap_wdata = 32'hA5A50000 + 32'(p);
            @(negedge clk);
        end
        bus.cap_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("prerst rd_valid", 64'(bus.rd_valid), 64'd1);
        chk("prerst rd_pc", 64'(bus.rd_pc), 64'd10);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst state", 64'(state), 64'd0);
        chk("async_rst count", 64'(count), 64'd0);
        chk("async_rst overflow", 64'(overflow), 64'd0);
        chk("async_rst rd_valid", 64'(bus.rd_valid), 64'd0);
        chk("async_rst rd_last", 64'(bus.rd_last), 64'd0);
        chk("async_rst rd_pc", 64'(bus.rd_pc), 64'd0);
        chk("async_rst rd_instr", 64'(bus.rd_instr), 64'd0);
        chk("async_rst rd_wdata", 64'(bus.rd_wdata), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got %0d failures of %0d", n_fail, n_checks);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mips_trace_buffer.md
Name: mips_trace_buffer

Overview:
- Synthesizable, parametrised successor to the mini-MIPS bench's per-cycle $monitor of pc, instruction and write data.
- Captures one retire record (pc, instruction, write-back data) per valid cycle into a circular buffer.
- Freezes the buffer on a pc-match trigger after a programmable number of post-trigger records, or on a forced stop.
- Drains the records oldest-first over a valid/ready stream. Sits beside the Mips core; inputs are tapped from pc_current, instruction and write_data.

Parameters:
PC_W, 5, width of the captured pc
INSTR_W, 16, instruction width
DATA_W, 32, write-back data width
DEPTH, 16, records held; power of 2, at least 2
POST_TRIG, 8, records captured after the trigger record; 0 to DEPTH-1

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
cap_valid  in  1  a record is presented this cycle
cap_pc  in  PC_W  record pc
cap_instr  in  INSTR_W  record instruction
cap_wdata  in  DATA_W  record write-back data
arm  in  1  start capture; honoured only in IDLE
trig_en  in  1  enable pc-match trigger
trig_pc  in  PC_W  trigger pc
stop  in  1  force freeze; honoured in ARMED/POST
rd_ready  in  1  consumer accepts rd record
rd_valid  out  1  rd record valid
rd_pc  out  PC_W  drained pc
rd_instr  out  INSTR_W  drained instruction
rd_wdata  out  DATA_W  drained write-back data
rd_last  out  1  current rd record is the final one
state  out  2  IDLE=0, ARMED=1, POST=2, DRAIN=3
count  out  $clog2(DEPTH)+1  valid records held
overflow  out  1  older records were overwritten

Behaviour:
- Reset (async, rst_n low): state IDLE; count 0; overflow 0; rd_valid 0; rd_last 0; rd_pc, rd_instr and rd_wdata all 0; pointers 0. Reset mid-drain or mid-capture discards everything.
- IDLE: ignores cap_valid and stop. On arm: clear wr_ptr, count and overflow, then go to ARMED. The arm-cycle record is not captured.
- ARMED, on cap_valid:
  - Write the record at wr_ptr and increment wr_ptr (wraps mod DEPTH).
  - count saturates at DEPTH. A write while count==DEPTH sets overflow, which stays set until next arm.
  - If trig_en and cap_pc==trig_pc, that record is stored. Go to POST with post_cnt=POST_TRIG, or straight to DRAIN if POST_TRIG==0.
- POST: each cap_valid writes as in ARMED and decrements post_cnt; the write that brings post_cnt to 0 goes to DRAIN. Trigger matches are ignored.
- stop in ARMED/POST:
  - Takes priority over a same-cycle record; that record is not written.
  - Goes to DRAIN if count>0, else to IDLE.
- DRAIN:
  - rd_ptr = wr_ptr - count (mod DEPTH) on entry; remaining = count. cap_valid and arm are ignored.
  - On the first cycle in DRAIN the output register loads the oldest record. rd_valid=1 from the next cycle.
  - rd data and rd_last are stable while rd_valid && !rd_ready.
  - On an rd_valid && rd_ready edge, the next record loads on that same edge with no bubble, and remaining decrements.
  - rd_last=1 exactly when remaining==1. Accepting with rd_last high clears rd_valid and rd_last, sets count to 0 and returns to IDLE. overflow holds until next arm.
- Trigger compare is an exact PC_W equality, qualified only by cap_valid.
- Records are never duplicated or dropped in DRAIN under any rd_ready pattern.

Decomposition:
- Shared package mips_dbg_pkg holds:
  - the state enum (IDLE/ARMED/POST/DRAIN, 2 bits);
  - localparam ENTRY_W = PC_W+INSTR_W+DATA_W;
  - the field-packing order {pc, instr, wdata}.
- Sub-module trace_ram: DEPTH x ENTRY_W, one synchronous write port, one asynchronous read port, no reset on storage.
- The top level holds the FSM, pointers, counters and output register.

Test Plan:
All scenarios use DEPTH=8, POST_TRIG=3, trig_en=1 and rd_ready=1 unless stated.
- Reset: assert rst_n=0 mid-stream -> state=0, count=0, overflow=0, rd_valid=0, all rd data 0 asynchronously.
- Basic trigger: arm, trig_pc=2, feed pc 0..9 one per cycle -> DRAIN after pc 5 is written, count=6. Drain gives pc 0,1,2,3,4,5 in order, rd_last only on pc 5, overflow=0, then state=0.
- Wrap: arm, trig_pc=12, feed pc 0..20 -> freeze after pc 15, count=8, overflow=1. Drain gives pc 8..15, with rd_instr and rd_wdata matching the fed records.
- Backpressure: repeat Basic trigger with rd_ready toggling 1,0,0,1,... -> each record is held while rd_ready=0, the sequence is exactly pc 0..5, and nothing is skipped or repeated.
- Forced stop: arm, feed pc 0..2, assert stop with cap_valid=1 and pc=3 -> count=3, drain gives pc 0..2 only. Arm, then stop with no records -> state IDLE next cycle, rd_valid never rises.
- Trigger gaps: arm, trig_pc=4, feed pc 4 then idle cycles (cap_valid=0), then pc 5,6,7 -> remains in POST during idle cycles and freezes after pc 7. A stray arm during POST/DRAIN has no effect.
